am_depth_meter: RTL

- Sits directly downstream of the AM DC-removal stage.
- Consumes the DC-free AM waveform and the DC level that stage estimated, and measures the AC peak amplitude over a fixed sample window.
- Computes modulation depth ma = A_peak / DC as an unsigned fixed-point word using a bit-serial divider.
- Result goes to the measurement readout / display path.

---
 rtl/am_depth_meter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/am_depth_meter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | am_depth_meter                                                           |
// | Windowed AC peak amplitude and AM modulation depth (A_peak / DC) meter.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module am_depth_meter #(
   parameter int IO_width  = 14,
   parameter int CNT_WIDTH = 32,
   parameter int WIN_LEN   = 28800,
   parameter int FRAC_BITS = 10
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic                       sample_en,
   input  logic signed [IO_width-1:0] AM_AC,
   input  logic signed [IO_width-1:0] DC,
   output logic                       busy,
   output logic [IO_width-2:0]        amp,
   output logic [FRAC_BITS+1:0]       depth,
   output logic                       dready,
   output logic                       err
);

   localparam int c_num_w = IO_width - 1 + FRAC_BITS;
   localparam int c_bit_w = $clog2(c_num_w + 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_MEAS = 3'd1,
      S_AMP  = 3'd2,
      S_DIV  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t                      r_state, w_state_nxt;
   logic signed [IO_width-1:0]  r_dc, r_max, r_min;
   logic [CNT_WIDTH-1:0]        r_cnt;
   logic [IO_width-2:0]         r_amp_calc, r_amp;
   logic                        r_err_calc, r_err;
   logic [FRAC_BITS+1:0]        r_depth;
   logic                        r_dready;
   logic [c_num_w-1:0]          r_num, r_quo;
   logic [IO_width-1:0]         r_rem;
   logic [c_bit_w-1:0]          r_bit;
   logic [IO_width:0]           w_diff, w_rem_sh, w_rem_sub;
   logic                        w_ge, w_dc_pos, w_last, w_sat, w_unused;

   assign w_diff    = {r_max[IO_width-1], r_max} - {r_min[IO_width-1], r_min};
   // Remainder stays below dc_r, so the shifted value always fits IO_width+1 bits.
   assign w_rem_sh  = {r_rem, r_num[c_num_w-1]};
   assign w_rem_sub = w_rem_sh - {1'b0, r_dc};
   assign w_ge      = (w_rem_sh >= {1'b0, r_dc});
   assign w_dc_pos  = !r_dc[IO_width-1] && (r_dc != '0);
   assign w_last    = (r_cnt == CNT_WIDTH'(WIN_LEN - 1));
   assign w_sat     = |r_quo[c_num_w-1:FRAC_BITS+2];
   assign w_unused  = ^{w_diff[IO_width], w_diff[0], w_rem_sub[IO_width]};

   assign busy   = (r_state != S_IDLE);
   assign amp    = r_amp;
   assign depth  = r_depth;
   assign dready = r_dready;
   assign err    = r_err;

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (start) w_state_nxt = S_MEAS;
         S_MEAS:  if (sample_en && w_last) w_state_nxt = S_AMP;
         S_AMP:   w_state_nxt = w_dc_pos ? S_DIV : S_DONE;
         S_DIV:   if (r_bit == c_bit_w'(c_num_w - 1)) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_dc       <= '0;
         r_max      <= '0;
         r_min      <= '0;
         r_cnt      <= '0;
         r_amp_calc <= '0;
         r_amp      <= '0;
         r_err_calc <= 1'b0;
         r_err      <= 1'b0;
         r_depth    <= '0;
         r_dready   <= 1'b0;
         r_num      <= '0;
         r_quo      <= '0;
         r_rem      <= '0;
         r_bit      <= '0;
      end else begin
         r_dready <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_dc  <= DC;
                  r_cnt <= '0;
                  r_max <= {1'b1, {(IO_width-1){1'b0}}};
                  r_min <= {1'b0, {(IO_width-1){1'b1}}};
               end
            end
            S_MEAS: begin
               if (sample_en) begin
                  if (AM_AC > r_max) r_max <= AM_AC;
                  if (AM_AC < r_min) r_min <= AM_AC;
                  r_cnt <= r_cnt + CNT_WIDTH'(1);
               end
            end
            S_AMP: begin
               r_amp_calc <= w_diff[IO_width-1:1];
               r_rem      <= '0;
               r_bit      <= '0;
               if (w_dc_pos) begin
                  r_err_calc <= 1'b0;
                  r_num      <= {w_diff[IO_width-1:1], {FRAC_BITS{1'b0}}};
                  r_quo      <= '0;
               end else begin
                  r_err_calc <= 1'b1;
                  r_quo      <= '1;
               end
            end
            S_DIV: begin
               r_num <= r_num << 1;
               r_quo <= {r_quo[c_num_w-2:0], w_ge};
               r_rem <= w_ge ? w_rem_sub[IO_width-1:0] : w_rem_sh[IO_width-1:0];
               r_bit <= r_bit + c_bit_w'(1);
            end
            S_DONE: begin
               r_amp    <= r_amp_calc;
               r_err    <= r_err_calc;
               r_depth  <= w_sat ? '1 : r_quo[FRAC_BITS+1:0];
               r_dready <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire
